// File: rtl/conv_2_4_div_pkg.sv
// Shared types and constants for the conv_2_4 sequential signed divider.
// Holds the FSM state encoding, default widths and quotient saturation limits.
package conv_2_4_div_pkg;

    localparam int unsigned DIVIDEND_W = 24;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned QUOTIENT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    localparam logic signed [QUOTIENT_W-1:0] QMAX = {1'b0, {(QUOTIENT_W-1){1'b1}}};
    localparam logic signed [QUOTIENT_W-1:0] QMIN = {1'b1, {(QUOTIENT_W-1){1'b0}}};

    // Bits needed to hold the values 0 .. v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned CNT_W = clog2(DIVIDEND_W);

endpackage

// File: rtl/conv_2_4_div_step.sv
// One restoring-division step: shift in the next dividend bit, then subtract
// the divisor magnitude when it fits, producing one quotient bit.
module conv_2_4_div_step
    import conv_2_4_div_pkg::*;
#(
    parameter int unsigned DIVISOR_WIDTH = DIVISOR_W
) (
    input  logic [DIVISOR_WIDTH:0]   rem_i,
    input  logic                     bit_i,
    input  logic [DIVISOR_WIDTH-1:0] dvsr_i,
    output logic [DIVISOR_WIDTH:0]   rem_o,
    output logic                     q_o
);

    logic [DIVISOR_WIDTH+1:0] shifted;
    logic [DIVISOR_WIDTH+1:0] dvsr_ext;

    // The partial remainder stays below |divisor|, so the top bit of the
    // difference is always zero and the cast back to DIVISOR_WIDTH+1 is lossless.
    always_comb begin
        shifted  = {rem_i, bit_i};
        dvsr_ext = {2'b00, dvsr_i};
        q_o      = (shifted >= dvsr_ext);
        rem_o    = (DIVISOR_WIDTH+1)'(q_o ? (shifted - dvsr_ext) : shifted);
    end

endmodule

// File: rtl/conv_2_4_div_seq.sv
// Sequential signed divider (restoring, one quotient bit per cycle) with
// valid/ready handshakes, quotient saturation and divide-by-zero reporting.
module conv_2_4_div_seq
    import conv_2_4_div_pkg::*;
#(
    parameter int unsigned DIVIDEND_WIDTH = DIVIDEND_W,
    parameter int unsigned DIVISOR_WIDTH  = DIVISOR_W,
    parameter int unsigned QUOTIENT_WIDTH = QUOTIENT_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      ovf,
    output logic                      dz
);

    localparam int unsigned CW = clog2(DIVIDEND_WIDTH);

    localparam logic [DIVIDEND_WIDTH-1:0] POS_LIM =
        DIVIDEND_WIDTH'((64'd1 << (QUOTIENT_WIDTH-1)) - 64'd1);
    localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIM =
        DIVIDEND_WIDTH'(64'd1 << (QUOTIENT_WIDTH-1));
    localparam logic [QUOTIENT_WIDTH-1:0] Q_MAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] Q_MIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d;
    logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
    logic [DIVISOR_WIDTH:0]    pr_q, pr_d;
    logic [DIVISOR_WIDTH-1:0]  dvsr_q, dvsr_d;
    logic                      dvd_neg_q, dvd_neg_d;
    logic                      dvs_neg_q, dvs_neg_d;
    logic                      dz_flag_q, dz_flag_d;
    logic [QUOTIENT_WIDTH-1:0] quot_q, quot_d;
    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    logic                      ovf_q, ovf_d;
    logic                      dz_q, dz_d;

    logic [DIVISOR_WIDTH:0]    step_rem;
    logic                      step_qbit;

    logic [DIVIDEND_WIDTH-1:0] dvd_abs;
    logic [DIVISOR_WIDTH-1:0]  dvs_abs;
    logic                      q_neg;
    logic [DIVIDEND_WIDTH-1:0] q_signed;
    logic                      sat_pos;
    logic                      sat_neg;
    logic [DIVISOR_WIDTH-1:0]  rem_signed;

    conv_2_4_div_step #(
        .DIVISOR_WIDTH(DIVISOR_WIDTH)
    ) u_step (
        .rem_i (pr_q),
        .bit_i (dvd_q[DIVIDEND_WIDTH-1]),
        .dvsr_i(dvsr_q),
        .rem_o (step_rem),
        .q_o   (step_qbit)
    );

    // Operand magnitudes; the most negative values map to 2^(W-1) as unsigned.
    always_comb begin
        dvd_abs = dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
        dvs_abs = divisor[DIVISOR_WIDTH-1]   ? -divisor  : divisor;
    end

    // Sign application and saturation detection on the magnitude quotient.
    always_comb begin
        q_neg      = dvd_neg_q ^ dvs_neg_q;
        q_signed   = q_neg ? -quo_q : quo_q;
        sat_pos    = !q_neg && (quo_q > POS_LIM);
        sat_neg    = q_neg && (quo_q > NEG_LIM);
        rem_signed = dvd_neg_q ? -pr_q[DIVISOR_WIDTH-1:0] : pr_q[DIVISOR_WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        pr_d      = pr_q;
        dvsr_d    = dvsr_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        dz_flag_d = dz_flag_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d     = dvd_abs;
                    dvsr_d    = dvs_abs;
                    dvd_neg_d = dividend[DIVIDEND_WIDTH-1];
                    dvs_neg_d = divisor[DIVISOR_WIDTH-1];
                    dz_flag_d = (divisor == '0);
                    pr_d      = '0;
                    quo_d     = '0;
                    cnt_d     = CW'(DIVIDEND_WIDTH-1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                pr_d  = step_rem;
                quo_d = {quo_q[DIVIDEND_WIDTH-2:0], step_qbit};
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A zero divisor still ran the full count; its result is discarded here.
                if (dz_flag_q) begin
                    quot_d = dvd_neg_q ? Q_MIN : Q_MAX;
                    rem_d  = '0;
                    ovf_d  = 1'b0;
                    dz_d   = 1'b1;
                end else begin
                    rem_d = rem_signed;
                    dz_d  = 1'b0;
                    if (sat_pos) begin
                        quot_d = Q_MAX;
                        ovf_d  = 1'b1;
                    end else if (sat_neg) begin
                        quot_d = Q_MIN;
                        ovf_d  = 1'b1;
                    end else begin
                        quot_d = QUOTIENT_WIDTH'(q_signed);
                        ovf_d  = 1'b0;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            pr_q      <= '0;
            dvsr_q    <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dz_flag_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            quo_q     <= quo_d;
            pr_q      <= pr_d;
            dvsr_q    <= dvsr_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            dz_flag_q <= dz_flag_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_conv_2_4_div_seq.sv
// Self-checking bench for conv_2_4_div_seq: scoreboard of expected results,
// checked against each result the divider presents.
module tb_conv_2_4_div_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dz;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic signed [31:0] q;
        logic signed [31:0] r;
        logic               ovf;
        logic               dz;
    } exp_t;

    exp_t sb[$];

    conv_2_4_div_seq #(
        .DIVIDEND_WIDTH(24),
        .DIVISOR_WIDTH (8),
        .QUOTIENT_WIDTH(16)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .ovf      (ovf),
        .dz       (dz)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference: truncating signed division, remainder follows the dividend, 16-bit saturation.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   tq;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        if (b == 0) begin
            e.dz = 1'b1;
            e.q  = (a >= 0) ? 32767 : -32768;
            e.r  = 0;
        end else begin
            tq  = a / b;
            e.r = a % b;
            if (tq > 32767) begin
                e.q = 32767;  e.ovf = 1'b1;
            end else if (tq < -32768) begin
                e.q = -32768; e.ovf = 1'b1;
            end else begin
                e.q = tq;
            end
        end
        return e;
    endfunction

    task automatic drive_accept(input int a, input int b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge ap_clk); #1; n++;
        end
        in_valid = 1'b1;
        dividend = 24'(a);
        divisor  = 8'(b);
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
    endtask

    // lat = index of the edge (after acceptance) at which out_valid is first sampled high.
    task automatic wait_out(output int lat, output bit to);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge ap_clk); #1; lat++;
        end
        to  = !out_valid;
        lat = lat + 1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, quotient, remainder, ovf, dz} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b q=%0d r=%0d ovf=%0b dz=%0b, want all 0",
                     out_valid, quotient, remainder, ovf, dz);
        end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk); ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b, want 1", in_ready);
        end
    endtask

    task automatic test_arith();
        int ta[9]  = '{1000, -1000, 1000, -1000, -8388608, 8388607, -32768, 12345, -5};
        int tb[9]  = '{7, 7, -7, -7, -128, 1, 1, 0, 0};
        int tq[9]  = '{142, -142, -142, 142, 32767, 32767, -32768, 32767, -32768};
        int tr[9]  = '{6, -6, 6, -6, 0, 0, 0, 0, 0};
        bit to[9]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
        bit tz[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        exp_t e;
        int   lat;
        bit   tmo;
        for (int i = 0; i < 9; i++) begin
            e.q = tq[i]; e.r = tr[i]; e.ovf = to[i]; e.dz = tz[i];
            sb.push_back(e);
            drive_accept(ta[i], tb[i]);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL arith_busy[%0d]: in_ready got %0b, want 0", i, in_ready);
            end
            wait_out(lat, tmo);
            checks++;
            if (tmo) begin
                errors++;
                $display("FAIL arith_timeout[%0d]: out_valid got 0, want 1 within 40 cycles", i);
                void'(sb.pop_front());
                continue;
            end
            e = sb.pop_front();
            if (lat != 26) begin
                errors++;
                $display("FAIL arith_latency[%0d]: got %0d, want 26", i, lat);
            end
            checks++;
            if (quotient !== 16'(e.q) || remainder !== 8'(e.r)) begin
                errors++;
                $display("FAIL arith_value[%0d] %0d/%0d: got q=%0d r=%0d, want q=%0d r=%0d",
                         i, ta[i], tb[i], $signed(quotient), $signed(remainder), e.q, e.r);
            end
            checks++;
            if (ovf !== e.ovf || dz !== e.dz) begin
                errors++;
                $display("FAIL arith_flags[%0d]: got ovf=%0b dz=%0b, want ovf=%0b dz=%0b",
                         i, ovf, dz, e.ovf, e.dz);
            end
            @(posedge ap_clk); #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL arith_release[%0d]: got in_ready=%0b out_valid=%0b, want 1/0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        int          lat;
        bit          tmo;
        logic [25:0] snap;
        out_ready = 1'b0;
        sb.push_back(model(5000, -9));
        drive_accept(5000, -9);
        wait_out(lat, tmo);
        checks++;
        if (tmo || lat != 26) begin
            errors++;
            $display("FAIL bp_latency: got %0d (timeout=%0b), want 26", lat, tmo);
        end
        e = sb.pop_front();
        checks++;
        if (quotient !== 16'(e.q) || remainder !== 8'(e.r)) begin
            errors++;
            $display("FAIL bp_value: got q=%0d r=%0d, want q=%0d r=%0d",
                     $signed(quotient), $signed(remainder), e.q, e.r);
        end
        snap = {quotient, remainder, ovf, dz};
        in_valid = 1'b1; dividend = 24'(777); divisor = 8'(5);
        for (int c = 0; c < 10; c++) begin
            @(posedge ap_clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {quotient, remainder, ovf, dz} !== snap) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%0b rdy=%0b out=%h, want 1/0/%h",
                         c, out_valid, in_ready, {quotient, remainder, ovf, dz}, snap);
            end
        end
        out_ready = 1'b1;
        sb.push_back(model(777, 5));
        @(posedge ap_clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake: got in_ready=%0b out_valid=%0b, want 1/0", in_ready, out_valid);
        end
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept: in_ready got %0b, want 0", in_ready);
        end
        wait_out(lat, tmo);
        e = sb.pop_front();
        checks++;
        if (tmo || lat != 26 || quotient !== 16'(e.q) || remainder !== 8'(e.r)) begin
            errors++;
            $display("FAIL bp_second: got lat=%0d q=%0d r=%0d, want lat=26 q=%0d r=%0d",
                     lat, $signed(quotient), $signed(remainder), e.q, e.r);
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_back_to_back();
        int   a[4];
        int   b[4];
        int   n_acc, n_res, last_acc, cyc;
        bit   acc_now;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            a[i] = int'($signed(24'($urandom)));
            b[i] = int'($urandom_range(0, 255)) - 128;
        end
        b[2] = 0;
        n_acc = 0; n_res = 0; last_acc = -1; cyc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; dividend = 24'(a[0]); divisor = 8'(b[0]);
        while (n_res < 4 && cyc < 300) begin
            acc_now = 1'b0;
            if (in_valid && in_ready) begin
                sb.push_back(model(a[n_acc], b[n_acc]));
                if (n_acc > 0) begin
                    checks++;
                    if (cyc - last_acc != 27) begin
                        errors++;
                        $display("FAIL b2b_interval[%0d]: got %0d cycles, want 27", n_acc, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_acc++;
                acc_now = 1'b1;
            end
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got q=%0d with no pending operation, want none",
                             $signed(quotient));
                end else begin
                    e = sb.pop_front();
                    if (quotient !== 16'(e.q) || remainder !== 8'(e.r) || ovf !== e.ovf || dz !== e.dz) begin
                        errors++;
                        $display("FAIL b2b_value[%0d]: got q=%0d r=%0d ovf=%0b dz=%0b, want q=%0d r=%0d ovf=%0b dz=%0b",
                                 n_res, $signed(quotient), $signed(remainder), ovf, dz, e.q, e.r, e.ovf, e.dz);
                    end
                end
                n_res++;
            end
            @(posedge ap_clk); #1;
            cyc++;
            if (acc_now) begin
                if (n_acc < 4) begin
                    dividend = 24'(a[n_acc]); divisor = 8'(b[n_acc]);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (n_res != 4 || n_acc != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d accepts %0d results, want 4/4", n_acc, n_res);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midcalc();
        exp_t e;
        int   lat;
        bit   tmo;
        drive_accept(5000, 7);
        repeat (11) @(posedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, quotient, remainder, ovf, dz} !== 27'd0) begin
            errors++;
            $display("FAIL midcalc_reset_outputs: got v=%0b q=%0d r=%0d ovf=%0b dz=%0b, want all 0",
                     out_valid, quotient, remainder, ovf, dz);
        end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk); ap_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge ap_clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL midcalc_stale[%0d]: got out_valid=%0b in_ready=%0b, want 0/1",
                         c, out_valid, in_ready);
            end
        end
        e.q = 33; e.r = 1; e.ovf = 1'b0; e.dz = 1'b0;
        sb.push_back(e);
        drive_accept(100, 3);
        wait_out(lat, tmo);
        e = sb.pop_front();
        checks++;
        if (tmo || lat != 26) begin
            errors++;
            $display("FAIL midcalc_latency: got %0d (timeout=%0b), want 26", lat, tmo);
        end
        checks++;
        if (quotient !== 16'(e.q) || remainder !== 8'(e.r) || ovf !== e.ovf || dz !== e.dz) begin
            errors++;
            $display("FAIL midcalc_value: got q=%0d r=%0d ovf=%0b dz=%0b, want q=33 r=1 ovf=0 dz=0",
                     $signed(quotient), $signed(remainder), ovf, dz);
        end
        @(posedge ap_clk); #1;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_midcalc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
